// File: rtl/mem_pkg.sv
// Shared data-memory definitions: load size/sign codes and the memory address width.
package mem_pkg;

  // funct3 size/sign codes understood by data_memory.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_ctrl_t;

  localparam int DMEM_ADDR_WIDTH = 12;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports plus the data_memory side of the arbiter.
interface dmem_arbiter_if
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
);

  // Port 0: core load/store path.
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [2:0]            req0_ctrl;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;

  // Port 1: debug/loader path.
  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [2:0]            req1_ctrl;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_lock;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  // Memory side.
  logic                  mem_write;
  logic [2:0]            mem_ctrl;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_we, req0_ctrl, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_ctrl, req1_addr, req1_wdata, req1_lock,
    input  mem_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_write, mem_ctrl, mem_addr, mem_wdata
  );

  // Requester/memory side.
  modport master (
    output req0_valid, req0_we, req0_ctrl, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_ctrl, req1_addr, req1_wdata, req1_lock,
    output mem_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_write, mem_ctrl, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. A set lock restricts the grant to requester 1.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock,
  output logic [1:0] gnt
);

  // Grant: lock masks requester 0; on conflict the requester not served last wins.
  always_comb begin
    gnt = 2'b00;
    if (lock) begin
      gnt = {req[1], 1'b0};
    end else begin
      case (req)
        2'b00:   gnt = 2'b00;
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data_memory between the core (port 0) and the debug/loader (port 1).
// One beat per clock; responses are registered one cycle after the grant.
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  logic [1:0]            req_s;
  logic [1:0]            gnt_s;
  logic [ADDR_WIDTH-1:0] addr_s;

  logic                  last_q, last_d;
  logic                  lock_q, lock_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

  assign req_s = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .req  (req_s),
    .last (last_q),
    .lock (lock_q),
    .gnt  (gnt_s)
  );

  assign bus.req0_ready = gnt_s[0];
  assign bus.req1_ready = gnt_s[1];
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;
  assign bus.mem_addr   = addr_s;

  // Memory field mux: port 1 only when granted, otherwise port 0 with write gated by its grant.
  always_comb begin
    bus.mem_write = 1'b0;
    bus.mem_ctrl  = bus.req0_ctrl;
    addr_s        = bus.req0_addr;
    bus.mem_wdata = bus.req0_wdata;
    if (gnt_s[1]) begin
      bus.mem_write = bus.req1_we;
      bus.mem_ctrl  = bus.req1_ctrl;
      addr_s        = bus.req1_addr;
      bus.mem_wdata = bus.req1_wdata;
    end else begin
      bus.mem_write = gnt_s[0] & bus.req0_we;
    end
  end

  // Next state: priority/lock tracking and response capture for the granted beat.
  always_comb begin
    last_d       = last_q;
    lock_d       = lock_q;
    rsp0_valid_d = gnt_s[0];
    rsp1_valid_d = gnt_s[1];
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    if (gnt_s[1]) begin
      last_d = 1'b1;
      lock_d = bus.req1_lock;
    end else if (gnt_s[0]) begin
      last_d = 1'b0;
    end else begin
      last_d = last_q;
    end
    // Store responses leave the load data register untouched.
    if (gnt_s[0] && !bus.req0_we) begin
      rsp0_rdata_d = bus.mem_rdata;
    end else begin
      rsp0_rdata_d = rsp0_rdata_q;
    end
    if (gnt_s[1] && !bus.req1_we) begin
      rsp1_rdata_d = bus.mem_rdata;
    end else begin
      rsp1_rdata_d = rsp1_rdata_q;
    end
  end

  // State registers; reset gives the core first priority and clears any lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q       <= 1'b1;
      lock_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp1_rdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      last_q       <= last_d;
      lock_q       <= lock_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data_memory model.
module tb_dmem_arbiter;
  import mem_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory model: byte array, little endian, combinational read, synchronous write.
  logic [7:0] mem_q [0:4095];
  logic [11:0] a0_s, a1_s, a2_s, a3_s;
  logic [31:0] word_s;

  assign a0_s = bus.mem_addr;
  assign a1_s = bus.mem_addr + 12'd1;
  assign a2_s = bus.mem_addr + 12'd2;
  assign a3_s = bus.mem_addr + 12'd3;
  assign word_s = {mem_q[a3_s], mem_q[a2_s], mem_q[a1_s], mem_q[a0_s]};

  always_comb begin
    bus.mem_rdata = word_s;
    case (bus.mem_ctrl)
      3'b000:  bus.mem_rdata = {{24{word_s[7]}}, word_s[7:0]};
      3'b001:  bus.mem_rdata = {{16{word_s[15]}}, word_s[15:0]};
      3'b100:  bus.mem_rdata = {24'h000000, word_s[7:0]};
      3'b101:  bus.mem_rdata = {16'h0000, word_s[15:0]};
      default: bus.mem_rdata = word_s;
    endcase
  end

  always @(posedge clk) begin
    if (rst && bus.mem_write) begin
      case (bus.mem_ctrl[1:0])
        2'b00: mem_q[a0_s] <= bus.mem_wdata[7:0];
        2'b01: begin
          mem_q[a0_s] <= bus.mem_wdata[7:0];
          mem_q[a1_s] <= bus.mem_wdata[15:8];
        end
        default: begin
          mem_q[a0_s] <= bus.mem_wdata[7:0];
          mem_q[a1_s] <= bus.mem_wdata[15:8];
          mem_q[a2_s] <= bus.mem_wdata[23:16];
          mem_q[a3_s] <= bus.mem_wdata[31:24];
        end
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic we, input logic [2:0] ctrl,
                        input logic [11:0] addr, input logic [31:0] wdata);
    bus.req0_valid = v;
    bus.req0_we    = we;
    bus.req0_ctrl  = ctrl;
    bus.req0_addr  = addr;
    bus.req0_wdata = wdata;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [2:0] ctrl,
                        input logic [11:0] addr, input logic [31:0] wdata, input logic lock);
    bus.req1_valid = v;
    bus.req1_we    = we;
    bus.req1_ctrl  = ctrl;
    bus.req1_addr  = addr;
    bus.req1_wdata = wdata;
    bus.req1_lock  = lock;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic e0;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    drive0(1'b0, 1'b0, LW, 12'h000, 32'h0);
    drive1(1'b0, 1'b0, LW, 12'h000, 32'h0, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    check_val("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    check_val("rst_rsp0_rdata", bus.rsp0_rdata, 32'h0);
    check_val("rst_rsp1_rdata", bus.rsp1_rdata, 32'h0);
    check_val("rst_last", {31'd0, dut.last_q}, 32'd1);
    check_val("rst_lock", {31'd0, dut.lock_q}, 32'd0);
    check_val("idle_mem_write", {31'd0, bus.mem_write}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Preload through the debug port (leaves last on port 1, same as after reset).
    drive1(1'b1, 1'b1, 3'b010, 12'h010, 32'h11223344, 1'b0);
    #1;
    check_val("pre_ready1", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    check_val("pre_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
    drive1(1'b1, 1'b1, 3'b010, 12'h050, 32'hCAFEF00D, 1'b0);
    tick();

    // Conflict: port 0 LW wins first, then port 1 SW.
    drive0(1'b1, 1'b0, LW, 12'h010, 32'h0);
    drive1(1'b1, 1'b1, 3'b010, 12'h020, 32'hDEADBEEF, 1'b0);
    #1;
    check_val("c0_ready0", {31'd0, bus.req0_ready}, 32'd1);
    check_val("c0_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    check_val("c0_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    check_val("c0_rsp0_rdata", bus.rsp0_rdata, 32'h11223344);
    check_val("c0_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    check_val("c1_ready0", {31'd0, bus.req0_ready}, 32'd0);
    check_val("c1_ready1", {31'd0, bus.req1_ready}, 32'd1);
    check_val("c1_mem_write", {31'd0, bus.mem_write}, 32'd1);
    check_val("c1_mem_addr", {20'd0, bus.mem_addr}, 32'h020);
    check_val("c1_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    tick();
    check_val("c1_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
    check_val("c1_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    check_val("c1_rsp1_rdata_hold", bus.rsp1_rdata, 32'h0);
    drive1(1'b0, 1'b0, LW, 12'h000, 32'h0, 1'b0);
    drive0(1'b1, 1'b0, LW, 12'h020, 32'h0);
    #1;
    check_val("rb_ready0", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    check_val("rb_rsp0_rdata", bus.rsp0_rdata, 32'hDEADBEEF);

    // Port 1 alone so the alternation below starts with port 0.
    drive0(1'b0, 1'b0, LW, 12'h000, 32'h0);
    drive1(1'b1, 1'b0, LW, 12'h010, 32'h0, 1'b0);
    tick();
    check_val("p1_rsp1_rdata", bus.rsp1_rdata, 32'h11223344);

    // Both valid for 6 cycles: grants 0,1,0,1,0,1.
    drive0(1'b1, 1'b0, LW, 12'h010, 32'h0);
    drive1(1'b1, 1'b0, LW, 12'h020, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      e0 = (i % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      check_val($sformatf("alt%0d_ready0", i), {31'd0, bus.req0_ready}, {31'd0, e0});
      check_val($sformatf("alt%0d_ready1", i), {31'd0, bus.req1_ready}, {31'd0, ~e0});
      tick();
      check_val($sformatf("alt%0d_rsp0", i), {31'd0, bus.rsp0_valid}, {31'd0, e0});
      check_val($sformatf("alt%0d_rsp1", i), {31'd0, bus.rsp1_valid}, {31'd0, ~e0});
    end

    // Lock: port 1 SW with lock, then idles; port 0 must stay stalled.
    drive0(1'b0, 1'b0, LW, 12'h000, 32'h0);
    drive1(1'b1, 1'b1, 3'b010, 12'h030, 32'h000000A5, 1'b1);
    #1;
    check_val("lk_ready1", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    drive1(1'b0, 1'b0, LW, 12'h000, 32'h0, 1'b0);
    drive0(1'b1, 1'b0, LW, 12'h020, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("lk%0d_ready0", i), {31'd0, bus.req0_ready}, 32'd0);
      tick();
      check_val($sformatf("lk%0d_rsp0", i), {31'd0, bus.rsp0_valid}, 32'd0);
    end
    drive1(1'b1, 1'b0, LW, 12'h030, 32'h0, 1'b0);
    #1;
    check_val("ul_ready1", {31'd0, bus.req1_ready}, 32'd1);
    check_val("ul_ready0", {31'd0, bus.req0_ready}, 32'd0);
    tick();
    check_val("ul_rsp1_rdata", bus.rsp1_rdata, 32'h000000A5);
    drive1(1'b0, 1'b0, LW, 12'h000, 32'h0, 1'b0);
    #1;
    check_val("ul_ready0_after", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    check_val("ul_rsp0_rdata", bus.rsp0_rdata, 32'hDEADBEEF);

    // Byte loads: SB 0x80 at 0x041, then LBU and LB.
    drive0(1'b1, 1'b1, 3'b000, 12'h041, 32'h00000080);
    tick();
    drive0(1'b1, 1'b0, LBU, 12'h041, 32'h0);
    #1;
    check_val("lbu_ready0", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    check_val("lbu_rdata", bus.rsp0_rdata, 32'h00000080);
    drive0(1'b1, 1'b0, LB, 12'h041, 32'h0);
    tick();
    check_val("lb_rdata", bus.rsp0_rdata, 32'hFFFFFF80);

    // Reset in the middle of a locked port-1 store.
    drive0(1'b0, 1'b0, LW, 12'h000, 32'h0);
    drive1(1'b1, 1'b0, LW, 12'h010, 32'h0, 1'b1);
    tick();
    drive1(1'b1, 1'b1, 3'b010, 12'h050, 32'h12345678, 1'b1);
    #1;
    check_val("mr_ready1", {31'd0, bus.req1_ready}, 32'd1);
    check_val("mr_lock_before", {31'd0, dut.lock_q}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("mr_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    check_val("mr_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    check_val("mr_lock", {31'd0, dut.lock_q}, 32'd0);
    check_val("mr_last", {31'd0, dut.last_q}, 32'd1);
    drive1(1'b0, 1'b0, LW, 12'h000, 32'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    drive0(1'b1, 1'b0, LW, 12'h050, 32'h0);
    drive1(1'b1, 1'b0, LW, 12'h010, 32'h0, 1'b0);
    #1;
    check_val("pr_ready0", {31'd0, bus.req0_ready}, 32'd1);
    check_val("pr_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    check_val("pr_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    check_val("pr_no_store", bus.rsp0_rdata, 32'hCAFEF00D);

    drive0(1'b0, 1'b0, LW, 12'h000, 32'h0);
    drive1(1'b0, 1'b0, LW, 12'h000, 32'h0, 1'b0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
